// File: rtl/mem_stage_sb.sv
// Pipeline memory stage with a store buffer that drains to the data cache in the background.
// Loads forward from the youngest overlapping store, or wait for it to drain and then read the cache.
module mem_stage_sb #(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int SB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [XLEN-1:0]       in_wdata,
    input  logic [4:0]            in_rd,
    output logic                  out_valid,
    output logic [XLEN-1:0]       out_rdata,
    output logic [4:0]            out_rd,
    output logic                  out_misaligned,
    output logic                  dc_req_valid,
    input  logic                  dc_req_ready,
    output logic                  dc_req_we,
    output logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic [XLEN-1:0]       dc_req_wdata,
    output logic [XLEN/8-1:0]     dc_req_wstrb,
    input  logic                  dc_resp_valid,
    input  logic [XLEN-1:0]       dc_resp_rdata,
    output logic                  sb_empty
);

    localparam int NB = XLEN / 8;
    localparam int PW = $clog2(SB_DEPTH);

    typedef enum logic [1:0] {IDLE, LD_DRAIN, LD_REQ, LD_WAIT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] sb_addr [SB_DEPTH];
    logic [XLEN-1:0]       sb_data [SB_DEPTH];
    logic [NB-1:0]         sb_mask [SB_DEPTH];
    logic [PW-1:0]         head, tail, idx, yidx;
    logic [PW:0]           count;
    logic                  full, wr_hold, hit, covered, mis;
    logic                  op_valid, push, pop, drain_pres, rd_pres;
    logic [NB-1:0]         size_mask, in_mask, q_mask, ld_mask;
    logic [ADDR_WIDTH-1:0] in_dw, q_dw, ld_dw;
    logic [XLEN-1:0]       in_shdata;
    logic [2:0]            ld_lane, ld_f3;

    // Shift the addressed lanes down to bit 0 and extend to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] dw,
                                               input logic [2:0] lane,
                                               input logic [2:0] f3);
        logic [XLEN-1:0] sh;
        sh = dw >> {lane, 3'b000};
        case (f3)
            3'b000:  extend = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  extend = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b010:  extend = {{(XLEN-32){sh[31]}}, sh[31:0]};
            3'b100:  extend = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  extend = {{(XLEN-16){1'b0}}, sh[15:0]};
            3'b110:  extend = {{(XLEN-32){1'b0}}, sh[31:0]};
            default: extend = sh;
        endcase
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        size_mask = '0;
        mis       = 1'b0;
        case (in_funct3[1:0])
            2'd0: size_mask = NB'(8'h01);
            2'd1: begin size_mask = NB'(8'h03); mis = in_addr[0];      end
            2'd2: begin size_mask = NB'(8'h0F); mis = |in_addr[1:0];   end
            default: begin size_mask = '1;      mis = |in_addr[2:0];   end
        endcase
    end

    assign in_mask   = size_mask << in_addr[2:0];
    assign in_dw     = {in_addr[ADDR_WIDTH-1:3], 3'b000};
    assign in_shdata = in_wdata << {in_addr[2:0], 3'b000};
    assign full      = (count == (PW+1)'(SB_DEPTH));
    assign sb_empty  = (count == '0);

    assign in_ready  = (state == IDLE) && !(in_is_store && full);
    assign op_valid  = in_valid && in_ready && (in_is_load || in_is_store);
    assign push      = op_valid && in_is_store && !mis;

    // The overlap query is the incoming load while IDLE, else the captured load.
    assign q_dw   = (state == IDLE) ? in_dw : ld_dw;
    assign q_mask = (state == IDLE) ? in_mask : ld_mask;

    // Walk oldest to youngest so the last match is the youngest overlapping entry.
    always_comb begin
        hit  = 1'b0;
        yidx = head;
        idx  = head;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx = head + PW'(k);
            if (((PW+1)'(k) < count) && (sb_addr[idx] == q_dw) && |(sb_mask[idx] & q_mask)) begin
                hit  = 1'b1;
                yidx = idx;
            end
        end
    end

    assign covered = ((sb_mask[yidx] & q_mask) == q_mask);

    // A write already on the port stays there until accepted, even once a read is waiting.
    assign drain_pres   = !sb_empty && (!(state == LD_REQ || state == LD_WAIT) || wr_hold);
    assign rd_pres      = (state == LD_REQ) && !wr_hold;
    assign pop          = drain_pres && dc_req_ready;

    assign dc_req_valid = drain_pres || rd_pres;
    assign dc_req_we    = drain_pres;
    assign dc_req_addr  = drain_pres ? sb_addr[head] : ld_dw;
    assign dc_req_wdata = drain_pres ? sb_data[head] : '0;
    assign dc_req_wstrb = drain_pres ? sb_mask[head] : '0;

    // NOTE: the buffer payload is not reset; only the pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= in_dw;
            sb_data[tail] <= in_shdata;
            sb_mask[tail] <= in_mask;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            wr_hold        <= 1'b0;
            out_valid      <= 1'b0;
            out_rdata      <= '0;
            out_rd         <= '0;
            out_misaligned <= 1'b0;
            ld_dw          <= '0;
            ld_mask        <= '0;
            ld_lane        <= '0;
            ld_f3          <= '0;
        end else begin
            out_valid      <= 1'b0;
            out_misaligned <= 1'b0;
            wr_hold        <= drain_pres && !dc_req_ready;

            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (op_valid) begin
                        out_rd <= in_rd;
                        if (mis) begin
                            out_valid      <= 1'b1;
                            out_misaligned <= 1'b1;
                            out_rdata      <= '0;
                        end else if (in_is_store) begin
                            out_valid <= 1'b1;
                            out_rdata <= '0;
                        end else begin
                            ld_dw   <= in_dw;
                            ld_mask <= in_mask;
                            ld_lane <= in_addr[2:0];
                            ld_f3   <= in_funct3;
                            if (!hit) begin
                                state <= LD_REQ;
                            end else if (covered) begin
                                out_valid <= 1'b1;
                                out_rdata <= extend(sb_data[yidx], in_addr[2:0], in_funct3);
                            end else begin
                                state <= LD_DRAIN;
                            end
                        end
                    end
                end
                LD_DRAIN: if (!hit) state <= LD_REQ;
                LD_REQ:   if (rd_pres && dc_req_ready) state <= LD_WAIT;
                default: begin
                    if (dc_resp_valid) begin
                        out_valid <= 1'b1;
                        out_rdata <= extend(dc_resp_rdata, ld_lane, ld_f3);
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: a program-order memory model predicts load results and
// a cache model applies drained writes; completions and writes are checked from scoreboards.
module tb_mem_stage_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_is_load = 1'b0, in_is_store = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [63:0] in_addr = '0, in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        dc_req_ready = 1'b1;
    logic        dc_resp_valid = 1'b0;
    logic [63:0] dc_resp_rdata = '0;
    logic        in_ready, out_valid, out_misaligned, dc_req_valid, dc_req_we, sb_empty;
    logic [63:0] out_rdata, dc_req_addr, dc_req_wdata;
    logic [4:0]  out_rd;
    logic [7:0]  dc_req_wstrb;

    mem_stage_sb dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_rdata(out_rdata), .out_rd(out_rd), .out_misaligned(out_misaligned),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
        .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] rdata; logic [4:0] rd; logic mis; int cyc; } cexp_t;
    typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] strb; } wexp_t;

    cexp_t       cq[$];
    wexp_t       wq[$];
    bit [63:0]   arch [bit [63:0]];
    bit [63:0]   cmem [bit [63:0]];
    int          errors = 0, checks = 0;
    int          cyc = 0, wr_cnt = 0, rd_cnt = 0, req_pres = 0, rd_pres = 0, wr_cyc = 0, rd_cyc = 0;
    bit          rd_pend = 0, resp_stall = 0;
    logic [63:0] rd_addr_p = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [63:0] mem_get(input bit is_arch, input logic [63:0] a);
        if (is_arch) return arch.exists(a) ? arch[a] : 64'd0;
        return cmem.exists(a) ? cmem[a] : 64'd0;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [2:0] lane);
        logic [7:0] m;
        m = 8'((16'd1 << (1 << f3[1:0])) - 16'd1);
        return m << lane;
    endfunction

    function automatic bit [63:0] merge(input bit [63:0] old, input logic [63:0] d, input logic [7:0] m);
        bit [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] load_expect(input logic [2:0] f3, input logic [63:0] a);
        logic [63:0] sh;
        sh = mem_get(1'b1, {a[63:3], 3'b000}) >> (8 * a[2:0]);
        case (f3)
            3'b000: return {{56{sh[7]}}, sh[7:0]};
            3'b001: return {{48{sh[15]}}, sh[15:0]};
            3'b010: return {{32{sh[31]}}, sh[31:0]};
            3'b100: return {56'd0, sh[7:0]};
            3'b101: return {48'd0, sh[15:0]};
            3'b110: return {32'd0, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    task automatic preload(input logic [63:0] a, input bit [63:0] d);
        arch[a] = d;
        cmem[a] = d;
    endtask

    always @(posedge clk) cyc++;

    // Monitor and cache responder, sampling on the falling edge.
    always @(negedge clk) begin
        cexp_t e;
        wexp_t w;
        bit    rd_hs;
        rd_hs = 0;
        if (!reset) begin
            dc_resp_valid = 1'b0;
            rd_pend = 0;
        end else begin
            if (out_valid) begin
                check("completion_expected", 64'(cq.size() != 0), 64'd1);
                if (cq.size() != 0) begin
                    e = cq.pop_front();
                    check("out_rdata", out_rdata, e.rdata);
                    check("out_rd", 64'(out_rd), 64'(e.rd));
                    check("out_misaligned", 64'(out_misaligned), 64'(e.mis));
                    if (e.cyc >= 0) check("completion_latency", 64'(cyc), 64'(e.cyc));
                end
            end
            if (dc_req_valid) req_pres++;
            if (dc_req_valid && !dc_req_we) rd_pres++;
            if (dc_req_valid && dc_req_ready) begin
                if (dc_req_we) begin
                    wr_cnt++;
                    wr_cyc = cyc;
                    check("write_expected", 64'(wq.size() != 0), 64'd1);
                    if (wq.size() != 0) begin
                        w = wq.pop_front();
                        check("wr_addr", dc_req_addr, w.addr);
                        check("wr_strb", 64'(dc_req_wstrb), 64'(w.strb));
                        check("wr_data", merge(64'd0, dc_req_wdata, w.strb), merge(64'd0, w.data, w.strb));
                    end
                    cmem[dc_req_addr] = merge(mem_get(1'b0, dc_req_addr), dc_req_wdata, dc_req_wstrb);
                end else begin
                    rd_cnt++;
                    rd_cyc = cyc;
                    rd_hs = 1;
                    check("rd_addr_aligned", 64'(dc_req_addr[2:0]), 64'd0);
                end
            end
            dc_resp_valid = 1'b0;
            if (rd_pend && !resp_stall) begin
                dc_resp_valid = 1'b1;
                dc_resp_rdata = mem_get(1'b0, rd_addr_p);
                rd_pend = 0;
            end
            if (rd_hs) begin
                rd_pend = 1;
                rd_addr_p = dc_req_addr;
            end
        end
    end

    // Present one op from the posedge+1 phase and wait (bounded) for it to be accepted.
    task automatic do_op(input bit ld, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, input logic [4:0] rd, input bit fast);
        bit         done;
        bit         mis;
        logic [7:0] m;
        done = 0;
        mis = (a[2:0] % (3'd1 << f3[1:0])) != 0;
        m = lane_mask(f3, a[2:0]);
        in_valid = 1'b1; in_is_load = ld; in_is_store = !ld;
        in_funct3 = f3; in_addr = a; in_wdata = d; in_rd = rd;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                if (mis) begin
                    cq.push_back('{64'd0, rd, 1'b1, cyc + 1});
                end else if (!ld) begin
                    arch[{a[63:3], 3'b000}] = merge(mem_get(1'b1, {a[63:3], 3'b000}), d << (8 * a[2:0]), m);
                    wq.push_back('{{a[63:3], 3'b000}, d << (8 * a[2:0]), m});
                    cq.push_back('{64'd0, rd, 1'b0, cyc + 1});
                end else begin
                    cq.push_back('{load_expect(f3, a), rd, 1'b0, fast ? cyc + 1 : -1});
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        check("op_accepted", 64'(done), 64'd1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 200 && (cq.size() != 0 || !sb_empty); n++) begin
            @(posedge clk); #1;
        end
        check("completions_drained", 64'(cq.size()), 64'd0);
        check("buffer_drained", 64'(sb_empty), 64'd1);
    endtask

    initial begin
        int snap, snap2;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_sb_empty", 64'(sb_empty), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dc_req_valid", 64'(dc_req_valid), 64'd0);
        check("rst_out_rdata", out_rdata, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Forward a full word from the buffer with the cache stalled.
        dc_req_ready = 1'b0;
        snap = rd_pres;
        do_op(0, 3'b010, 64'h1004, 64'hDEADBEEF, 5'd1, 1);
        do_op(1, 3'b010, 64'h1004, 64'd0, 5'd2, 1);
        repeat (3) @(posedge clk); #1;
        check("fwd_no_read", 64'(rd_pres), 64'(snap));
        check("fwd_queue_empty", 64'(cq.size()), 64'd0);
        dc_req_ready = 1'b1;
        wait_done();

        // Partial overlap: byte store drains before the halfword read.
        preload(64'h2000, 64'h0000_0000_0000_AAAA);
        do_op(0, 3'b000, 64'h2001, 64'h11, 5'd3, 1);
        do_op(1, 3'b001, 64'h2000, 64'd0, 5'd4, 0);
        wait_done();
        check("drain_write_before_read", 64'(wr_cyc < rd_cyc), 64'd1);
        check("lh_merged_value", arch[64'h2000] & 64'hFFFF, 64'h11AA);

        // Full buffer: stores stall, a forwarded load still goes through.
        dc_req_ready = 1'b0;
        snap = wr_cnt;
        for (int i = 0; i < 4; i++)
            do_op(0, 3'b011, 64'h4000 + 64'(8 * i), 64'hA5A5_0000_0000_0000 + 64'(i), 5'(8 + i), 1);
        in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = 3'b011; in_addr = 64'h4020;
        @(negedge clk);
        check("full_store_stall", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_store = 1'b0;
        do_op(1, 3'b011, 64'h4008, 64'd0, 5'd12, 1);
        in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = 3'b011; in_addr = 64'h4020;
        dc_req_ready = 1'b1;
        @(negedge clk);
        check("full_stall_during_pop", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_store = 1'b0;
        wait_done();
        check("full_fifo_writes", 64'(wr_cnt - snap), 64'd4);

        // Misaligned ops touch nothing; byte loads extend correctly.
        preload(64'h3000, 64'h8000_0000_0000_0000);
        snap = req_pres;
        do_op(1, 3'b010, 64'h3002, 64'd0, 5'd7, 1);
        do_op(0, 3'b001, 64'h3001, 64'hFFFF, 5'd8, 1);
        repeat (3) @(posedge clk); #1;
        check("misaligned_no_req", 64'(req_pres), 64'(snap));
        check("misaligned_no_push", 64'(sb_empty), 64'd1);
        do_op(1, 3'b100, 64'h3007, 64'd0, 5'd9, 0);
        do_op(1, 3'b000, 64'h3007, 64'd0, 5'd10, 0);
        wait_done();

        // Ops flagged neither load nor store are ignored.
        in_valid = 1'b1; in_funct3 = 3'b011; in_addr = 64'h3000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("ignored_no_push", 64'(sb_empty), 64'd1);

        // Reset while a read is outstanding with two stores still buffered.
        preload(64'h6000, 64'h1234_5678_9ABC_DEF0);
        dc_req_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            do_op(0, 3'b011, 64'h5000 + 64'(8 * i), 64'(i + 1), 5'd0, 1);
        resp_stall = 1;
        snap = rd_cnt;
        do_op(1, 3'b011, 64'h6000, 64'd0, 5'd5, 0);
        dc_req_ready = 1'b1;
        for (int n = 0; n < 20 && rd_cnt == snap; n++) begin
            @(posedge clk); #1;
        end
        check("read_issued", 64'(rd_cnt), 64'(snap + 1));
        @(negedge clk);
        check("stores_left_in_wait", 64'(sb_empty), 64'd0);
        #2;
        reset = 1'b0;
        cq.delete();
        wq.delete();
        @(negedge clk);
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        check("rst2_sb_empty", 64'(sb_empty), 64'd1);
        check("rst2_dc_req_valid", 64'(dc_req_valid), 64'd0);
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        resp_stall = 0;
        repeat (2) @(posedge clk); #1;

        // Back-to-back stores wrap the pointers; then read two of them back.
        snap2 = wr_cnt;
        for (int i = 0; i < 12; i++)
            do_op(0, 3'(i % 4), 64'h7000 + 64'(8 * i) + 64'(8 - (1 << (i % 4))),
                  64'h0102_0304_0506_0708 * 64'(i + 1), 5'(i), 1);
        wait_done();
        check("wrap_write_count", 64'(wr_cnt - snap2), 64'd12);
        check("wrap_no_pending", 64'(wq.size()), 64'd0);
        do_op(1, 3'b011, 64'h7018, 64'd0, 5'd20, 0);
        do_op(1, 3'b110, 64'h7014, 64'd0, 5'd21, 0);
        do_op(1, 3'b101, 64'h7056, 64'd0, 5'd22, 0);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage_sb.md
Name: mem_stage_sb

Overview:
Parametrised successor to the pipeline memory stage. Sits between execute and writeback and fronts the data cache through a simple valid/ready request port. Stores retire into a DEPTH-entry store buffer that drains to the cache in the background. Loads are forwarded from the buffer when possible, with byte-lane alignment, sign/zero extension and misalignment detection.

Parameters:
XLEN, 64, data width in bits; must be 64 (8 byte lanes, dword granularity)
ADDR_WIDTH, 64, address width
SB_DEPTH, 4, store buffer entries, power of two, >=2

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset (0 = reset)
in_valid  in  1  load/store presented
in_ready  out  1  stage accepts op this cycle
in_is_load  in  1  op is load
in_is_store  in  1  op is store
in_funct3  in  3  B=000 H=001 W=010 D=011 BU=100 HU=101 WU=110
in_addr  in  ADDR_WIDTH  byte address
in_wdata  in  XLEN  store data, LSB-aligned
in_rd  in  5  load destination
out_valid  out  1  one-cycle completion pulse
out_rdata  out  XLEN  extended load data (0 for stores)
out_rd  out  5  rd of completed op
out_misaligned  out  1  completion was misaligned (no memory effect)
dc_req_valid  out  1  cache request
dc_req_ready  in  1  cache accepts request
dc_req_we  out  1  1 = write (buffer drain), 0 = read
dc_req_addr  out  ADDR_WIDTH  dword-aligned address (low 3 bits 0)
dc_req_wdata  out  XLEN  lane-positioned write data
dc_req_wstrb  out  XLEN/8  byte strobes
dc_resp_valid  in  1  read data valid
dc_resp_rdata  in  XLEN  read dword
sb_empty  out  1  store buffer empty (fence/drain indicator)

Behaviour:
- Reset (async, reset=0): FSM IDLE, buffer emptied (pending stores discarded), all outputs 0 except in_ready=1 and sb_empty=1.
- Size = 1<<funct3[1:0]; misaligned iff addr[2:0] is not a multiple of size. Misaligned op: no buffer push, no cache access, out_valid+out_misaligned at T+1.
- Byte mask = ((1<<size)-1)<<addr[2:0]; write data shifted left by 8*addr[2:0].
- Store accepted at T (in_valid & in_ready & in_is_store): push {dword addr, data, mask} at tail; out_valid at T+1, out_rdata=0. in_ready=0 for stores while buffer full, even if a pop occurs that cycle.
- in_ready = FSM==IDLE and not (store and full).
- Load accepted at T: search all valid entries with the same dword address whose mask overlaps the load mask; pick the youngest.
  - No overlap: FSM IDLE->LD_REQ.
  - Youngest overlapping mask covers the whole load mask: forward, out_valid at T+1, FSM stays IDLE.
  - Otherwise: IDLE->LD_DRAIN, load captured.
- LD_DRAIN: buffer keeps draining; once no overlapping entry remains, go to LD_REQ.
- LD_REQ: dc_req_valid=1, we=0. On handshake go to LD_WAIT.
- LD_WAIT: on dc_resp_valid, extract lanes, extend per funct3, register the result; out_valid the next cycle; return to IDLE. Exactly one outstanding read.
- Drain: when buffer non-empty and FSM not in LD_REQ/LD_WAIT, present the head as a write. Pop on dc_req_valid & dc_req_ready. Writes have no response.
- Request fields stay stable while dc_req_valid=1 and ready=0. A write already presented is held until accepted; a read is then issued next.
- Push and pop in the same cycle are legal when not full; the count is unchanged and pointers wrap modulo SB_DEPTH.
- in_valid with neither load nor store: ignored, no output.

Test Plan:
- SW addr 0x1004 data 0xDEADBEEF, then LD addr 0x1004 with no cache grant -> forwarded out_rdata=0xFFFFFFFFDEADBEEF at T+1; dc_req_valid never read.
- SB 0x11 @0x2001, then LH 0x2000, cache memory 0xAAAA -> LD_DRAIN; write wstrb=0x02 completes before read; out_rdata=0x11AA.
- Fill 4 stores with dc_req_ready=0 -> in_ready=0 for a 5th store, a load still accepted; raise ready -> 4 writes in FIFO order; sb_empty=1 after the last.
- LW addr 0x3002 -> out_misaligned=1 at T+1, no dc_req; LBU 0x3007 reading 0x80 in lane 7 -> out_rdata=0x80; LB -> 0xFFFFFFFFFFFFFF80.
- Reset=0 during LD_WAIT with 2 buffered stores -> next cycle in_ready=1, sb_empty=1, dc_req_valid=0, out_valid=0.
- 12 back-to-back stores with ready always 1 -> pointers wrap, all 12 writes appear in order, no drops.
